async_fifo_rd_ctrl: RTL and testbench

Read-side controller of the async FIFO, and the counterpart of the write-side pointer logic. It owns the binary/Gray read pointer and runs a 2-flop synchronizer plus Gray decoder for the incoming write pointer. It generates empty and occupancy, drives the synchronous-read RAM port, and presents data on a valid/ready stream through a 3-entry output queue, sustaining one word per cycle.

---
 rtl/async_fifo_rd_ctrl.sv | 158 +++++++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_ctrl
//
// Read-side controller of the async FIFO. Owns the binary/Gray read pointer,
// synchronizes and decodes the write pointer coming from the write domain,
// derives empty/occupancy, drives the synchronous-read RAM port and delivers
// words on a valid/ready stream through a 3-entry output queue.
//
// Ports
//   clk_i              read-domain clock
//   rst_i              synchronous active-high reset
//   wptr_gray_async_i  Gray write pointer from the write domain (asynchronous)
//   rd_en_o            RAM read strobe
//   rd_addr_o          RAM read address (low W bits of the binary read pointer)
//   rd_data_i          RAM data, valid the cycle after rd_en_o
//   dout_o             stream data (queue head)
//   dout_valid_o       queue head valid
//   dout_ready_i       consumer accept
//   rptr_gray_o        registered Gray read pointer, to the write domain
//   empty_o            no unread RAM entries visible
//   rd_count_o         visible unread entries, 0..2^W
// -----------------------------------------------------------------------------
module async_fifo_rd_ctrl #(
  parameter int W  = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [W:0]    wptr_gray_async_i,
  output logic          rd_en_o,
  output logic [W-1:0]  rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic [DW-1:0] dout_o,
  output logic          dout_valid_o,
  input  logic          dout_ready_i,
  output logic [W:0]    rptr_gray_o,
  output logic          empty_o,
  output logic [W:0]    rd_count_o
);

  // ---------------------------------------------------------------------------
  // Write pointer synchronizer: only these two flops see the async input.
  // ---------------------------------------------------------------------------
  logic [W:0] sync1_q;
  logic [W:0] wsync_gray_q;
  logic [W:0] wsync_bin;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= '0;
      wsync_gray_q <= '0;
    end else begin
      sync1_q      <= wptr_gray_async_i;
      wsync_gray_q <= sync1_q;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    wsync_bin = '0;
    for (int i = W; i >= 0; i--) begin
      acc          = acc ^ wsync_gray_q[i];
      wsync_bin[i] = acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pointer
  // ---------------------------------------------------------------------------
  logic [W:0] rptr_bin_q;
  logic [W:0] rptr_bin_d;
  logic [W:0] rptr_gray_q;
  logic [W:0] rptr_gray_d;
  logic       rd_en;

  always_comb begin
    rptr_bin_d  = rptr_bin_q + {{W{1'b0}}, rd_en};
    rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
    end
  end

  logic empty;
  assign empty = (rptr_gray_q == wsync_gray_q);

  // ---------------------------------------------------------------------------
  // Output queue (3-entry circular buffer) and credit tracking
  // ---------------------------------------------------------------------------
  logic [DW-1:0] qmem_q [3];
  logic [1:0]    head_q;
  logic [1:0]    head_d;
  logic [1:0]    qcnt_q;
  logic [1:0]    qcnt_d;
  logic          cap_q;     // a read issued last cycle lands on rd_data_i now
  logic          pop;
  logic [2:0]    committed;
  logic [2:0]    tail_sum;
  logic [1:0]    tail;

  assign pop = (qcnt_q != 2'd0) && dout_ready_i;

  always_comb begin
    // Slots already promised after this cycle: queued + landing - leaving.
    committed = {1'b0, qcnt_q} + {2'b00, cap_q} - {2'b00, pop};
    rd_en     = !rst_i && !empty && (committed < 3'd3);

    tail_sum  = {1'b0, head_q} + {1'b0, qcnt_q};
    tail      = (tail_sum >= 3'd3) ? 2'(tail_sum - 3'd3) : tail_sum[1:0];

    head_d    = head_q;
    if (pop) begin
      head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
    end
    qcnt_d    = committed[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      qcnt_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      qcnt_q <= qcnt_d;
      cap_q  <= rd_en;
    end
  end

  // Credits guarantee qcnt_q <= 2 whenever cap_q is set, so the tail never
  // lands on the head being read out.
  always_ff @(posedge clk_i) begin
    if (!rst_i && cap_q) begin
      qmem_q[tail] <= rd_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_en_o      = rd_en;
  assign rd_addr_o    = rptr_bin_q[W-1:0];
  assign rptr_gray_o  = rptr_gray_q;
  assign empty_o      = empty;
  assign rd_count_o   = wsync_bin - rptr_bin_q;
  assign dout_valid_o = (qcnt_q != 2'd0);
  assign dout_o       = (qcnt_q != 2'd0) ? qmem_q[head_q] : '0;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for async_fifo_rd_ctrl: directed vector table, hand-written corner
// sequences and a randomized run checked against a counter-based model.
// -----------------------------------------------------------------------------
module tb_async_fifo_rd_ctrl;
  localparam int W  = 4;
  localparam int DW = 8;
  localparam int D  = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W:0]    wptr_g;
  logic          rd_en;
  logic [W-1:0]  rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [W:0]    rptr_gray;
  logic          empty;
  logic [W:0]    rd_count;

  always #5 clk = ~clk;

  async_fifo_rd_ctrl #(.W(W), .DW(DW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .wptr_gray_async_i (wptr_g),
    .rd_en_o           (rd_en),
    .rd_addr_o         (rd_addr),
    .rd_data_i         (rd_data),
    .dout_o            (dout),
    .dout_valid_o      (dout_valid),
    .dout_ready_i      (dout_ready),
    .rptr_gray_o       (rptr_gray),
    .empty_o           (empty),
    .rd_count_o        (rd_count)
  );

  // Synchronous-read RAM
  logic [DW-1:0] ram [D];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int total = 0;
  int bad   = 0;

  // Model: words written, words read from RAM, words popped, and the write
  // count as it was one and two cycles ago (what the read side can see).
  int   wcnt, rissued, npop, wc1, wc2;
  logic prev_stall;
  logic [DW-1:0] prev_dout;

  function automatic logic [W:0] gray(input int n);
    logic [W:0] b;
    b = n[W:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DW-1:0] dat(input int w);
    return DW'(w * 29 + 17);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_write();
    ram[wcnt % D] = dat(wcnt);
    wcnt++;
    wptr_g = gray(wcnt);
  endtask

  task automatic model_clear();
    wcnt = 0; rissued = 0; npop = 0; wc1 = 0; wc2 = 0;
    prev_stall = 1'b0; prev_dout = '0;
  endtask

  // Called at the negedge of every non-reset cycle.
  task automatic observe();
    int vis;
    vis = wc2 - rissued;
    chk("rd_count", 32'(rd_count), 32'(vis));
    chk("empty", 32'(empty), 32'(vis == 0));
    chk("rptr_gray", 32'(rptr_gray), 32'(gray(rissued)));
    chk("rd_en_when_empty", 32'(rd_en && (vis == 0)), 32'(0));
    chk("valid_without_data", 32'(dout_valid && (npop >= rissued)), 32'(0));
    if (prev_stall) begin
      chk("hold_valid", 32'(dout_valid), 32'(1));
      chk("hold_dout", 32'(dout), 32'(prev_dout));
    end
    if (rd_en) begin
      chk("rd_addr", 32'(rd_addr), 32'(rissued % D));
      rissued++;
    end
    if (dout_valid) begin
      chk("dout", 32'(dout), 32'(dat(npop)));
      if (dout_ready) npop++;
    end
    prev_stall = dout_valid && !dout_ready;
    prev_dout  = dout;
    chk("credits", 32'((rissued - npop) <= 3), 32'(1));
    wc2 = wc1;
    wc1 = wcnt;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      wptr_g     = (W+1)'($urandom_range(0, 2**(W+1) - 1));
      dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i >= 1) begin
        chk("rst_rd_en", 32'(rd_en), 32'(0));
        chk("rst_rd_addr", 32'(rd_addr), 32'(0));
        chk("rst_rptr_gray", 32'(rptr_gray), 32'(0));
        chk("rst_dout_valid", 32'(dout_valid), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_rd_count", 32'(rd_count), 32'(0));
      end
      @(posedge clk); #1;
    end
    rst        = 1'b0;
    wptr_g     = '0;
    dout_ready = 1'b0;
    model_clear();
  endtask

  typedef struct {
    int wr; int rdy;
    int e_rd_en; int e_addr; int e_empty; int e_cnt; int e_rg; int e_valid; int e_dout;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wraps;
    int last_addr;
    int have_last;

    rst = 1'b1; wptr_g = '0; dout_ready = 1'b0;
    model_clear();

    // wr rdy | rd_en addr empty cnt rg valid dout
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 1, 1, int'(dat(0))};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 1, 1, int'(dat(0))};
    tbl[6]  = '{0, 1, 0, 1, 1, 0, 1, 1, int'(dat(0))};
    tbl[7]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 0, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 2, 1, 0, 3, 0, 0};
    tbl[12] = '{0, 1, 0, 2, 1, 0, 3, 1, int'(dat(1))};
    tbl[13] = '{0, 0, 0, 2, 1, 0, 3, 0, 0};

    // Reset and single-entry latency table
    do_reset(2);
    for (int k = 0; k < 14; k++) begin
      if (tbl[k].wr != 0) do_write();
      dout_ready = (tbl[k].rdy != 0);
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", k), 32'(rd_en), 32'(tbl[k].e_rd_en));
      chk($sformatf("v%0d_rd_addr", k), 32'(rd_addr), 32'(tbl[k].e_addr));
      chk($sformatf("v%0d_empty", k), 32'(empty), 32'(tbl[k].e_empty));
      chk($sformatf("v%0d_rd_count", k), 32'(rd_count), 32'(tbl[k].e_cnt));
      chk($sformatf("v%0d_rptr_gray", k), 32'(rptr_gray), 32'(tbl[k].e_rg));
      chk($sformatf("v%0d_valid", k), 32'(dout_valid), 32'(tbl[k].e_valid));
      if (tbl[k].e_valid != 0)
        chk($sformatf("v%0d_dout", k), 32'(dout), 32'(tbl[k].e_dout));
      observe();
      @(posedge clk); #1;
    end

    // Streaming: 8 words, consumer always ready
    do_reset(2);
    for (int i = 0; i < 8; i++) do_write();
    dout_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_rd_en", k), 32'(rd_en), 32'(k >= 2 && k <= 9));
      chk($sformatf("stream%0d_valid", k), 32'(dout_valid), 32'(k >= 4 && k <= 11));
      observe();
      @(posedge clk); #1;
    end
    chk("stream_popped", 32'(npop), 32'(8));
    chk("stream_empty", 32'(empty), 32'(1));

    // Backpressure
    do_reset(2);
    for (int i = 0; i < 8; i++) do_write();
    for (int k = 0; k < 10; k++) tick();
    chk("bp_stall_reads", 32'(rissued), 32'(3));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("bp_one_more_read", 32'(rissued), 32'(4));
    chk("bp_one_pop", 32'(npop), 32'(1));
    dout_ready = 1'b1;
    for (int k = 0; k < 40 && npop < 8; k++) tick();
    chk("bp_drained", 32'(npop), 32'(8));
    chk("bp_reads", 32'(rissued), 32'(8));

    // Wrap: 40 words with writes kept ahead
    do_reset(2);
    dout_ready = 1'b1;
    wraps = 0; last_addr = 0; have_last = 0;
    for (int k = 0; k < 300 && npop < 40; k++) begin
      if (wcnt < 40 && (wcnt - rissued) < D) do_write();
      @(negedge clk);
      if (rd_en) begin
        if (have_last != 0 && last_addr == D - 1 && int'(rd_addr) == 0) wraps++;
        last_addr = int'(rd_addr);
        have_last = 1;
      end
      observe();
      @(posedge clk); #1;
    end
    chk("wrap_popped", 32'(npop), 32'(40));
    chk("wrap_count", 32'(wraps), 32'(2));
    chk("wrap_rptr_msb", 32'(rptr_gray[W]), 32'(0));

    // Full: write pointer 16 ahead of a wrapped read pointer
    dout_ready = 1'b0;
    for (int i = 0; i < D; i++) do_write();
    tick();
    tick();
    @(negedge clk);
    chk("full_rd_count", 32'(rd_count), 32'(D));
    chk("full_empty", 32'(empty), 32'(0));
    observe();
    @(posedge clk); #1;
    dout_ready = 1'b1;
    for (int k = 0; k < 80 && npop < 56; k++) tick();
    chk("full_drained", 32'(npop), 32'(56));

    // Randomized traffic with two consumer duty cycles
    for (int ph = 0; ph < 2; ph++) begin
      do_reset(2);
      for (int k = 0; k < 700; k++) begin
        if ($urandom_range(0, 99) < 60 && (wcnt - rissued) < D) do_write();
        dout_ready = ($urandom_range(0, 99) < (ph == 0 ? 75 : 30));
        tick();
      end
      dout_ready = 1'b1;
      for (int k = 0; k < 100 && npop < wcnt; k++) tick();
      chk($sformatf("rand%0d_drained", ph), 32'(npop), 32'(wcnt));
    end

    // Reset mid-stream: queue non-empty, a read in flight
    do_reset(2);
    for (int i = 0; i < 8; i++) do_write();
    for (int k = 0; k < 5; k++) tick();
    chk("mid_reads_before_rst", 32'(rissued), 32'(3));
    chk("mid_valid_before_rst", 32'(dout_valid), 32'(1));
    rst = 1'b1;
    wptr_g = '0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    dout_ready = 1'b1;
    model_clear();
    @(negedge clk);
    chk("mid_rd_en", 32'(rd_en), 32'(0));
    chk("mid_rd_addr", 32'(rd_addr), 32'(0));
    chk("mid_rptr_gray", 32'(rptr_gray), 32'(0));
    chk("mid_dout_valid", 32'(dout_valid), 32'(0));
    chk("mid_dout", 32'(dout), 32'(0));
    chk("mid_empty", 32'(empty), 32'(1));
    chk("mid_rd_count", 32'(rd_count), 32'(0));
    observe();
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("mid_stale%0d", k), 32'(dout_valid), 32'(0));
      observe();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
